// File: rtl/crc5_check.sv
// CRC5 codeword checker: recomputes CRC5 (x^5+x^2+1) over a 64-bit payload, one byte per cycle.
// Optional mismatch counter port err_cnt is enabled by defining CRC5_CHK_ERRCNT_EN.
module crc5_check (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [4:0]  crc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        crc_ok,
    output logic [4:0]  crc_calc
`ifdef CRC5_CHK_ERRCNT_EN
    ,output logic [7:0] err_cnt
`endif
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CRC_W-1:0] POLY = 5'h05;
    localparam logic [CNT_W-1:0] LAST_BYTE = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [CRC_W-1:0]  r_crc_in;
    logic [CRC_W-1:0]  r_lfsr;
    logic [CRC_W-1:0]  w_lfsr_nxt;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_crc_ok;
    logic [CRC_W-1:0]  r_crc_calc;

    // MSB-first serial CRC step applied to all 8 bits of one byte
    function automatic logic [CRC_W-1:0] crc5_byte(input logic [CRC_W-1:0] c,
                                                   input logic [BYTE_W-1:0] d);
        logic [CRC_W-1:0]  r;
        logic [BYTE_W-1:0] dd;
        logic              fb;
        r  = c;
        dd = d;
        for (int i = 0; i < 8; i++) begin
            fb = r[CRC_W-1] ^ dd[BYTE_W-1];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
            dd = {dd[BYTE_W-2:0], 1'b0};
        end
        return r;
    endfunction

    assign w_lfsr_nxt = crc5_byte(r_lfsr, r_data[DATA_W-1 -: BYTE_W]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)                  w_state_nxt = ST_CALC;
            ST_CALC: if (r_byte_cnt == LAST_BYTE)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)                 w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: payload is shifted left so the current byte is always at the top
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data      <= '0;
            r_crc_in    <= '0;
            r_lfsr      <= '0;
            r_byte_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_crc_calc  <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data     <= data_in;
                        r_crc_in   <= crc_in;
                        r_lfsr     <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    r_lfsr     <= w_lfsr_nxt;
                    r_data     <= {r_data[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    if (r_byte_cnt == LAST_BYTE) begin
                        r_crc_calc <= w_lfsr_nxt;
                        r_crc_ok   <= (w_lfsr_nxt == r_crc_in);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign crc_ok    = r_crc_ok;
    assign crc_calc  = r_crc_calc;

`ifdef CRC5_CHK_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts failed results on their consuming handshake, saturating at 8'hFF
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_DONE) && out_ready && !r_crc_ok && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_crc5_check.sv
// Scoreboard bench for crc5_check: driver queues expected results, monitor compares on out_valid rise.
// Define CRC5_CHK_ERRCNT_EN to also exercise the err_cnt port.
module tb_crc5_check;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [4:0]  crc_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        crc_ok;
    logic [4:0]  crc_calc;
`ifdef CRC5_CHK_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    crc5_check dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .crc_in    (crc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_ok    (crc_ok),
        .crc_calc  (crc_calc)
`ifdef CRC5_CHK_ERRCNT_EN
        ,.err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] calc;
        logic       ok;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_rises = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC by polynomial long division of d*x^5 by 100101
    function automatic logic [4:0] ref_crc(input logic [63:0] d);
        logic [68:0] m;
        m = {d, 5'b00000};
        for (int i = 68; i >= 5; i--) begin
            if (m[i]) m[i -: 6] = m[i -: 6] ^ 6'b100101;
        end
        return m[4:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare each new result against the oldest expectation
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev) begin
                valid_rises++;
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("crc_calc", 64'(crc_calc), 64'(e.calc));
                    chk("crc_ok", 64'(crc_ok), 64'(e.ok));
                    chk("latency_edge", 64'(cyc), 64'(e.due));
                end
            end
            prev = out_valid;
        end
    end

    task automatic send(input logic [63:0] d, input logic [4:0] c,
                        input logic [4:0] ec, input logic eo, input logic push);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        data_in  = d;
        crc_in   = c;
        @(posedge clk);
        #1;
        e.calc = ec;
        e.ok   = eo;
        e.due  = cyc + 8;
        if (push) sb.push_back(e);
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
        crc_in   = 5'($urandom);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [63:0] d;
        logic [4:0]  c;
        int          rises;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_crc_ok", 64'(crc_ok), 64'd0);
        chk("rst_crc_calc", 64'(crc_calc), 64'd0);
`ifdef CRC5_CHK_ERRCNT_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        rst = 1'b1;

        send(64'h0, 5'b00000, 5'b00000, 1'b1, 1'b1);
        wait_result();
        send(64'h1, 5'b00101, 5'b00101, 1'b1, 1'b1);
        wait_result();
        send(64'h2, 5'b01010, 5'b01010, 1'b1, 1'b1);
        wait_result();
        send(64'h1, 5'b00100, 5'b00101, 1'b0, 1'b1);
        wait_result();
`ifdef CRC5_CHK_ERRCNT_EN
        chk("err_cnt_after_bad", 64'(err_cnt), 64'd1);
`endif

        // Result held while downstream stalls; in_valid pulses ignored
        out_ready = 1'b0;
        send(64'h2, 5'b01010, 5'b01010, 1'b1, 1'b1);
        wait_result();
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            data_in  = {$urandom, $urandom};
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_crc_calc", 64'(crc_calc), 64'h0a);
            chk("hold_crc_ok", 64'(crc_ok), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("exit_out_valid", 64'(out_valid), 64'd0);
        chk("exit_in_ready", 64'(in_ready), 64'd1);
        chk("idle_crc_calc_held", 64'(crc_calc), 64'h0a);
        chk("idle_crc_ok_held", 64'(crc_ok), 64'd1);
        repeat (3) @(negedge clk);

        // Reset glitch between edges must not disturb a codeword in flight
        send(64'h1, 5'b00101, 5'b00101, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("glitch_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        wait_result();

        // Reset at the 4th CALC edge aborts the codeword
        rises = valid_rises;
        send(64'h0123_4567_89ab_cdef, 5'h00, 5'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_crc_calc", 64'(crc_calc), 64'd0);
`ifdef CRC5_CHK_ERRCNT_EN
        chk("abort_err_cnt", 64'(err_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_result", 64'(valid_rises), 64'(rises));

        // Random payloads with good CRC, then the same payload with one bit flipped
        for (int t = 0; t < 6; t++) begin
            d = {$urandom, $urandom};
            c = ref_crc(d);
            send(d, c, c, 1'b1, 1'b1);
            wait_result();
            d = d ^ (64'h1 << $urandom_range(0, 63));
            send(d, c, ref_crc(d), 1'b0, 1'b1);
            wait_result();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/crc5_check.md
CRC5_CHECK -- requirements
Module: crc5_check

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 in_valid  input  1  codeword offered on data_in/crc_in.
REQ-004 in_ready  output  1  block can accept a codeword; high only in IDLE.
REQ-005 data_in  input  64  received payload.
REQ-006 crc_in  input  5  received CRC5 transmitted alongside the payload.
REQ-007 out_valid  output  1  check result available; high only in DONE.
REQ-008 out_ready  input  1  downstream consumes the result.
REQ-009 crc_ok  output  1  1 = recomputed CRC equals crc_in.
REQ-010 crc_calc  output  5  recomputed CRC of the captured payload.
REQ-011 err_cnt  output  8  mismatch counter; port exists only when CRC5_CHK_ERRCNT_EN is defined.

Function
REQ-012 CRC algorithm: generator x^5+x^2+1 (0x05), init 5'b00000, MSB-first, no reflection, no final XOR; matches the team's crc5 generator.
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 at an edge captures data_in, crc_in; clears LFSR and byte counter; goes to CALC.
REQ-015 CALC: one byte per cycle, bits [63:56] first, down to [7:0]; 3-bit byte counter; after the 8th byte, goes to DONE.
REQ-016 Latency: out_valid rises exactly 8 clock edges after the accepting edge.
REQ-017 DONE: out_valid=1, crc_calc=final LFSR, crc_ok=(crc_calc==crc_in captured); held stable until out_ready=1 at an edge, then goes to IDLE.
REQ-018 No back-to-back accept: in_ready stays 0 on the edge that leaves DONE; next accept at the earliest one cycle later.
REQ-019 Inputs data_in/crc_in ignored outside the accepting edge; in_valid during CALC/DONE has no effect.
REQ-020 out_ready while not in DONE has no effect.
REQ-021 crc_ok and crc_calc hold their last DONE values in IDLE/CALC until the next DONE.

Reset
REQ-022 rst=0 at an edge: state=IDLE, LFSR=0, byte counter=0, captured registers=0, crc_ok=0, crc_calc=0, out_valid=0, in_ready=1 after that edge.
REQ-023 Reset during CALC or DONE aborts the codeword; no result is produced; err_cnt is cleared.
REQ-024 No asynchronous path: rst change between edges has no effect until the next edge.

Configuration
REQ-025 Macro CRC5_CHK_ERRCNT_EN defined: err_cnt increments by 1 on each DONE-exit handshake with crc_ok=0, saturates at 8'hFF, resets to 0.
REQ-026 Macro undefined: no err_cnt port or counter; all other behaviour identical.

Verification
REQ-027 Reset then data_in=64'h0, crc_in=5'b00000 -> out_valid 8 edges after accept, crc_calc=5'b00000, crc_ok=1.
REQ-028 data_in=64'h1, crc_in=5'b00101 -> crc_calc=5'b00101, crc_ok=1; data_in=64'h2, crc_in=5'b01010 -> crc_ok=1.
REQ-029 data_in=64'h1, crc_in=5'b00100 -> crc_calc=5'b00101, crc_ok=0; with CRC5_CHK_ERRCNT_EN, err_cnt 0->1 after out_ready.
REQ-030 out_ready held 0 for 5 cycles in DONE -> out_valid, crc_ok, crc_calc stable; in_valid pulses ignored; in_ready=0.
REQ-031 rst=0 at the 4th CALC cycle -> next edge IDLE, in_ready=1, out_valid never asserts for that codeword.
REQ-032 Random 64-bit payloads with CRC from the crc5 generator -> crc_ok=1 every time; single flipped payload bit -> crc_ok=0.
